// File: rtl/rgb2gray_axis_nppc.sv
// rgb2gray_axis_nppc: converts PPC packed 24-bit RGB pixels per AXI4-Stream beat
// into PPC 8-bit luma values, y = sat255((R*COEF_R + G*COEF_G + B*COEF_B + rnd) >> 8).
// Three-stage stallable pipeline with per-stage valid bits; full backpressure.
//
// Optional feature macro: RGB2GRAY_ROUND_EN
//   defined   -> rnd = 128 (round to nearest)
//   undefined -> rnd = 0   (truncation, bit-exact with the previous generation)
//
// Ports:
//   s_axis_video_aclk    clock, rising edge
//   s_axis_video_areset  asynchronous active-high reset
//   VIDEO_IN_*           input stream, pixel k at tdata[24k+:24], G=[7:0] B=[15:8] R=[23:16]
//   VIDEO_IN_tready      combinational: !v3 || VIDEO_OUT_tready
//   VIDEO_OUT_*          output stream, grey pixel k at tdata[8k+:8], registered

module rgb2gray_axis_nppc #(
  parameter int unsigned PPC    = 4,
  parameter int unsigned COEF_R = 77,
  parameter int unsigned COEF_G = 150,
  parameter int unsigned COEF_B = 29
) (
  input  logic               s_axis_video_aclk,
  input  logic               s_axis_video_areset,
  input  logic [24*PPC-1:0]  VIDEO_IN_tdata,
  input  logic               VIDEO_IN_tvalid,
  output logic               VIDEO_IN_tready,
  input  logic               VIDEO_IN_tuser,
  input  logic               VIDEO_IN_tlast,
  output logic [8*PPC-1:0]   VIDEO_OUT_tdata,
  output logic               VIDEO_OUT_tvalid,
  input  logic               VIDEO_OUT_tready,
  output logic               VIDEO_OUT_tuser,
  output logic               VIDEO_OUT_tlast
);

  localparam logic [7:0] CR = 8'(COEF_R);
  localparam logic [7:0] CG = 8'(COEF_G);
  localparam logic [7:0] CB = 8'(COEF_B);
`ifdef RGB2GRAY_ROUND_EN
  localparam logic [16:0] RND = 17'd128;
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  logic clk;
  logic rst;
  assign clk = s_axis_video_aclk;
  assign rst = s_axis_video_areset;

  logic v1, v2, v3;
  logic u1, u2, u3;
  logic l1, l2, l3;
  logic [PPC-1:0][15:0] pr_q, pg_q, pb_q;
  logic [PPC-1:0][16:0] srg_q;
  logic [PPC-1:0][15:0] pb2_q;
  logic [PPC-1:0][16:0] sum_c;
  logic [PPC-1:0][7:0]  y_c;
  logic [PPC-1:0][7:0]  y_q;
  logic en;

  // Whole pipeline advances unless the output beat is stuck waiting on the sink.
  assign en              = !v3 || VIDEO_OUT_tready;
  assign VIDEO_IN_tready = en;

  // S1: per-lane weighted products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      u1   <= 1'b0;
      l1   <= 1'b0;
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
    end else if (en) begin
      v1 <= VIDEO_IN_tvalid;
      u1 <= VIDEO_IN_tuser;
      l1 <= VIDEO_IN_tlast;
      for (int k = 0; k < int'(PPC); k++) begin
        pr_q[k] <= 16'(VIDEO_IN_tdata[24*k+16 +: 8]) * 16'(CR);
        pg_q[k] <= 16'(VIDEO_IN_tdata[24*k    +: 8]) * 16'(CG);
        pb_q[k] <= 16'(VIDEO_IN_tdata[24*k+8  +: 8]) * 16'(CB);
      end
    end
  end

  // S2: partial sum R+G, blue product delayed to stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      u2    <= 1'b0;
      l2    <= 1'b0;
      srg_q <= '0;
      pb2_q <= '0;
    end else if (en) begin
      v2 <= v1;
      u2 <= u1;
      l2 <= l1;
      for (int k = 0; k < int'(PPC); k++) begin
        srg_q[k] <= 17'(pr_q[k]) + 17'(pg_q[k]);
        pb2_q[k] <= pb_q[k];
      end
    end
  end

  // Final sum, rounding offset, >>8 and saturation (bit 16 set means y > 255)
  always_comb begin
    sum_c = '0;
    y_c   = '0;
    for (int k = 0; k < int'(PPC); k++) begin
      sum_c[k] = srg_q[k] + 17'(pb2_q[k]) + RND;
      y_c[k]   = sum_c[k][16] ? 8'hFF : sum_c[k][15:8];
    end
  end

  // S3: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3  <= 1'b0;
      u3  <= 1'b0;
      l3  <= 1'b0;
      y_q <= '0;
    end else if (en) begin
      v3  <= v2;
      u3  <= u2;
      l3  <= l2;
      y_q <= y_c;
    end
  end

  assign VIDEO_OUT_tvalid = v3;
  assign VIDEO_OUT_tuser  = u3;
  assign VIDEO_OUT_tlast  = l3;
  assign VIDEO_OUT_tdata  = y_q;

endmodule

// File: tb/tb_rgb2gray_axis_nppc.sv
// Self-checking bench for rgb2gray_axis_nppc: scoreboard of expected beats fed on
// input acceptance and popped on output acceptance, plus directed checks.
// Honours RGB2GRAY_ROUND_EN the same way as the design build.

module tb_rgb2gray_axis_nppc;

`ifdef RGB2GRAY_ROUND_EN
  localparam int unsigned RND_TB = 128;
  localparam logic [31:0] EXP_PRIM = {8'd255, 8'd29, 8'd149, 8'd77};
`else
  localparam int unsigned RND_TB = 0;
  localparam logic [31:0] EXP_PRIM = {8'd255, 8'd28, 8'd149, 8'd76};
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tuser = 1'b0;
  logic        in_tlast = 1'b0;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tuser;
  logic        out_tlast;

  // Equal-weight instances (85/85/85) at PPC=1 and PPC=8, free-running
  logic [23:0]  a_tdata = 24'hFFFFFF;
  logic [191:0] b_tdata = {8{24'hFFFFFF}};
  logic         ab_tvalid = 1'b0;
  logic         a_tready, b_tready;
  logic [7:0]   a_odata;
  logic [63:0]  b_odata;
  logic         a_ovalid, b_ovalid, a_ouser, b_ouser, a_olast, b_olast;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic        obs_valid;
  logic [31:0] obs_data;
  beat_t sb[$];

  always #5 clk = ~clk;

  rgb2gray_axis_nppc #(.PPC(4)) u_dut (
    .s_axis_video_aclk  (clk),
    .s_axis_video_areset(rst),
    .VIDEO_IN_tdata     (in_tdata),
    .VIDEO_IN_tvalid    (in_tvalid),
    .VIDEO_IN_tready    (in_tready),
    .VIDEO_IN_tuser     (in_tuser),
    .VIDEO_IN_tlast     (in_tlast),
    .VIDEO_OUT_tdata    (out_tdata),
    .VIDEO_OUT_tvalid   (out_tvalid),
    .VIDEO_OUT_tready   (out_tready),
    .VIDEO_OUT_tuser    (out_tuser),
    .VIDEO_OUT_tlast    (out_tlast)
  );

  rgb2gray_axis_nppc #(.PPC(1), .COEF_R(85), .COEF_G(85), .COEF_B(85)) u_dut1 (
    .s_axis_video_aclk  (clk),
    .s_axis_video_areset(rst),
    .VIDEO_IN_tdata     (a_tdata),
    .VIDEO_IN_tvalid    (ab_tvalid),
    .VIDEO_IN_tready    (a_tready),
    .VIDEO_IN_tuser     (1'b0),
    .VIDEO_IN_tlast     (1'b0),
    .VIDEO_OUT_tdata    (a_odata),
    .VIDEO_OUT_tvalid   (a_ovalid),
    .VIDEO_OUT_tready   (1'b1),
    .VIDEO_OUT_tuser    (a_ouser),
    .VIDEO_OUT_tlast    (a_olast)
  );

  rgb2gray_axis_nppc #(.PPC(8), .COEF_R(85), .COEF_G(85), .COEF_B(85)) u_dut8 (
    .s_axis_video_aclk  (clk),
    .s_axis_video_areset(rst),
    .VIDEO_IN_tdata     (b_tdata),
    .VIDEO_IN_tvalid    (ab_tvalid),
    .VIDEO_IN_tready    (b_tready),
    .VIDEO_IN_tuser     (1'b0),
    .VIDEO_IN_tlast     (1'b0),
    .VIDEO_OUT_tdata    (b_odata),
    .VIDEO_OUT_tvalid   (b_ovalid),
    .VIDEO_OUT_tready   (1'b1),
    .VIDEO_OUT_tuser    (b_ouser),
    .VIDEO_OUT_tlast    (b_olast)
  );

  // Reference luma for a 4-pixel beat with default coefficients
  function automatic logic [31:0] model(input logic [95:0] px);
    logic [31:0] y;
    logic [23:0] p;
    int unsigned s;
    y = '0;
    for (int k = 0; k < 4; k++) begin
      p = px[24*k +: 24];
      s = 77 * int'(p[23:16]) + 150 * int'(p[7:0]) + 29 * int'(p[15:8]) + RND_TB;
      s = s >> 8;
      if (s > 255) s = 255;
      y[8*k +: 8] = 8'(s);
    end
    return y;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check/score at +1, step over the edge, check stall hold
  task automatic cycle(input logic tv, input logic [95:0] td, input logic tu,
                       input logic tl, input logic ordy);
    beat_t e;
    logic  stall;
    logic [34:0] held;
    in_tvalid  = tv;
    in_tdata   = td;
    in_tuser   = tu;
    in_tlast   = tl;
    out_tready = ordy;
    #1;
    obs_valid = out_tvalid;
    obs_data  = out_tdata;
    chk("tready_rule", 96'(in_tready), 96'(!out_tvalid || ordy));
    if (out_tvalid && ordy) begin
      chk("beat_expected", 96'(sb.size() != 0), 96'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_tdata", 96'(out_tdata), 96'(e.d));
        chk("out_tuser", 96'(out_tuser), 96'(e.u));
        chk("out_tlast", 96'(out_tlast), 96'(e.l));
      end
    end
    if (tv && in_tready) begin
      sb.push_back('{model(td), tu, tl});
      n_acc++;
    end
    stall = out_tvalid && !ordy;
    held  = {out_tvalid, out_tdata, out_tuser, out_tlast};
    @(posedge clk);
    #1;
    if (stall) chk("stall_hold", 96'({out_tvalid, out_tdata, out_tuser, out_tlast}), 96'(held));
  endtask

  task automatic send_beat(input logic [95:0] td, input logic tu, input logic tl);
    int prev;
    prev = n_acc;
    for (int i = 0; i < 50 && n_acc == prev; i++) cycle(1'b1, td, tu, tl, 1'b1);
    chk("send_accepted", 96'(n_acc != prev), 96'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("drained", 96'(sb.size()), 96'(0));
  endtask

  initial begin
    logic [95:0] prim;
    logic [95:0] rd;
    int target;

    // Reset state
    #3;
    chk("rst_tvalid", 96'(out_tvalid), 96'(0));
    chk("rst_tdata",  96'(out_tdata),  96'(0));
    chk("rst_tuser",  96'({out_tuser, out_tlast}), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    ab_tvalid = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 96'(in_tready), 96'(1));

    // Primaries and white; output seen in the third cycle after the accept cycle
    prim = {24'hFFFFFF, 24'h00FF00, 24'h0000FF, 24'hFF0000};
    cycle(1'b1, prim, 1'b0, 1'b0, 1'b1);
    chk("prim_accepted", 96'(n_acc), 96'(1));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lat_c1_invalid", 96'(obs_valid), 96'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lat_c2_invalid", 96'(obs_valid), 96'(0));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lat_c3_valid", 96'(obs_valid), 96'(1));
    chk("prim_lanes", 96'(obs_data), 96'(EXP_PRIM));

    // Equal weights: 255*255 >> 8 = 254 in every lane, either build
    chk("ppc1_valid", 96'({a_ovalid, a_tready}), 96'(2'b11));
    chk("ppc1_lane",  96'(a_odata), 96'(8'd254));
    chk("ppc8_valid", 96'({b_ovalid, b_tready}), 96'(2'b11));
    chk("ppc8_lanes", 96'(b_odata), 96'({8{8'd254}}));
    chk("ppc_sideband", 96'({a_ouser, a_olast, b_ouser, b_olast}), 96'(0));

    // Empty pipeline with sink not ready keeps accepting until S3 fills
    cycle(1'b1, 96'h123456_abcdef_00ff80_7f7f7f, 1'b0, 1'b0, 1'b0);
    chk("empty_nr_accept", 96'(n_acc), 96'(2));
    drain();

    // Line of 8 beats, tuser on 0, tlast on 7, sink stalled for 5 cycles at beat 3
    for (int i = 0; i < 3; i++)
      send_beat({$urandom, $urandom, $urandom}, 1'(i == 0), 1'b0);
    rd = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) cycle(1'b1, rd, 1'b0, 1'b0, 1'b0);
    chk("stall_blocks_input", 96'(n_acc), 96'(5));
    for (int i = 3; i < 8; i++)
      send_beat((i == 3) ? rd : {$urandom, $urandom, $urandom}, 1'b0, 1'(i == 7));
    drain();

    // Random traffic: 50% valid, sink not ready 30% of the time
    target = n_acc + 1000;
    for (int c = 0; c < 20000 && n_acc < target; c++)
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) >= 3));
    chk("random_count", 96'(n_acc >= target), 96'(1));
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b1);
    in_tvalid = 1'b0;
    out_tready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 96'(out_tvalid), 96'(0));
    chk("async_rst_data",  96'(out_tdata),  96'(0));
    chk("async_rst_side",  96'({out_tuser, out_tlast}), 96'(0));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_post_rst", 96'(in_tready), 96'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("no_stale_beat", 96'(obs_valid), 96'(0));
    send_beat(prim, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
